cue_player: RTL
===============

CUE_PLAYER -- requirements
Module: cue_player

Interface
REQ-001 Parameter ON_CYCLES, default 25000000, SHALL set LED-lit duration per cue in clk cycles (250 ms at 100 MHz); legal range 1 to 2^32-1.
REQ-002 Parameter GAP_CYCLES, default 10000000, SHALL set dark gap after each cue in clk cycles (100 ms); legal range 1 to 2^32-1.
REQ-003 Parameters TONE_HALF0..TONE_HALF3, defaults 95557/75843/63776/47778, SHALL set buzzer half-period in cycles per color (C5/E5/G5/C6); legal range >=1.
REQ-004 clk  input  1  rising-edge clock; reset reset, synchronous, active-high; clock clk.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  cue request present.
REQ-007 req_color  input  2  color index 0-3 of requested cue.
REQ-008 req_ready  output  1  block can accept a cue this cycle.
REQ-009 stop  input  1  synchronous abort of current cue.
REQ-010 led  output  4  one-hot lamp drive, bit n = color n.
REQ-011 tone  output  1  buzzer square wave.
REQ-012 busy  output  1  high while in ON or GAP.
REQ-013 done  output  1  single-cycle pulse on normal cue completion.

Function
REQ-014 FSM SHALL have states IDLE, ON, GAP; all outputs registered.
REQ-015 req_ready SHALL be 1 exactly when state==IDLE and stop==0.
REQ-016 Handshake: cue accepted on a rising edge where req_valid&req_ready; req_color captured at that edge; req_color ignored otherwise.
REQ-017 After acceptance, state SHALL be ON for exactly ON_CYCLES cycles with led = 1<<color, then GAP for exactly GAP_CYCLES cycles with led=0, then IDLE.
REQ-018 done SHALL be 1 only in the first IDLE cycle following GAP; never after stop or reset.
REQ-019 Back-to-back: request accepted in the done cycle SHALL enter ON next cycle; cue period = ON_CYCLES+GAP_CYCLES+1 cycles.
REQ-020 busy SHALL equal (state!=IDLE); led SHALL be 0 in IDLE and GAP.
REQ-021 Duration counter SHALL be 32-bit down-counter loaded with N-1 on state entry; transition when it reads 0; no wrap.
REQ-022 stop in ON or GAP SHALL force IDLE next cycle, led=0, tone=0, no done; stop in IDLE SHALL block acceptance only.
REQ-023 stop and req_valid in the same IDLE cycle: stop wins, no acceptance.
REQ-024 Changes of req_valid/req_color while busy SHALL not affect the cue in progress.

Reset
REQ-025 reset SHALL override stop and req_valid and force state=IDLE, counters=0.
REQ-026 Outputs during and after reset: led=0, tone=0, busy=0, done=0, req_ready=1 in first cycle after reset deasserts (with stop=0).
REQ-027 Reset mid-cue SHALL abort with no done pulse.

Configuration
REQ-028 Macro CUE_PLAYER_TONE_EN defined: in ON, tone SHALL start 0 on ON entry and toggle every TONE_HALF<color> cycles; tone=0 outside ON.
REQ-029 Macro CUE_PLAYER_TONE_EN undefined: tone SHALL be constant 0, tone counter logic absent, port retained.

Verification (ON_CYCLES=4, GAP_CYCLES=2, TONE_HALF2=1, TONE_HALF0=2)
REQ-030 Single cue: color=2 accepted at edge 0 -> led=4'b0100 cycles 1-4, led=0 cycles 5-6, done=1 cycle 7 only, busy=1 cycles 1-6.
REQ-031 Back-to-back: req_valid held high colors 1 then 3 -> second cue ON begins cycle 8, led=4'b1000; period 7 cycles.
REQ-032 Abort: stop pulsed at cycle 2 of ON -> led=0 and busy=0 next cycle, done never asserts, req_ready=1 following cycle.
REQ-033 Priority: stop=1 with req_valid=1 in IDLE -> req_ready=0, no acceptance; reset asserted mid-GAP -> IDLE, done=0.
REQ-034 Tone (macro defined): color 2 -> tone 0,1,0,1 over ON cycles 1-4; color 0 -> 0,0,1,1; tone=0 in GAP. Macro undefined -> tone=0 throughout.

Source files
------------

// File: rtl/cue_player.sv
// cue_player: plays one lamp/tone cue per accepted request.
// A cue lights led[color] for ON_CYCLES, then stays dark for GAP_CYCLES,
// then returns to IDLE with a one-cycle done pulse.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req_valid/color cue request (color 0-3), accepted when req_ready
//   req_ready       high in IDLE while stop is low
//   stop            abort the running cue, or block acceptance in IDLE
//   led             one-hot lamp drive, zero outside ON
//   tone            buzzer square wave during ON (CUE_PLAYER_TONE_EN)
//   busy            high in ON and GAP
//   done            pulse in the first IDLE cycle after a completed cue
// Define CUE_PLAYER_TONE_EN to build the tone generator; otherwise
// tone is tied low.
module cue_player #(
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned GAP_CYCLES = 10000000,
    parameter int unsigned TONE_HALF0 = 95557,
    parameter int unsigned TONE_HALF1 = 75843,
    parameter int unsigned TONE_HALF2 = 63776,
    parameter int unsigned TONE_HALF3 = 47778
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_color,
    output logic       req_ready,
    input  logic       stop,
    output logic [3:0] led,
    output logic       tone,
    output logic       busy,
    output logic       done
);

    if (ON_CYCLES == 0 || GAP_CYCLES == 0 ||
        TONE_HALF0 == 0 || TONE_HALF1 == 0 ||
        TONE_HALF2 == 0 || TONE_HALF3 == 0) begin : g_bad_param
        $error("cue_player: durations must be >= 1");
    end

    localparam logic [31:0] ON_LD  = ON_CYCLES - 32'd1;
    localparam logic [31:0] GAP_LD = GAP_CYCLES - 32'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic        accept;
    logic        cnt_zero;

    // stop is an input, so ready must follow it within the cycle
    assign req_ready = (state == S_IDLE) && !stop;
    assign accept    = req_valid && req_ready;
    assign cnt_zero  = (cnt == 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 32'd0;
            led   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_ON;
                        cnt   <= ON_LD;
                        led   <= 4'd1 << req_color;
                        busy  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (stop) begin
                        state <= S_IDLE;
                        cnt   <= 32'd0;
                        led   <= 4'd0;
                        busy  <= 1'b0;
                    end else if (cnt_zero) begin
                        state <= S_GAP;
                        cnt   <= GAP_LD;
                        led   <= 4'd0;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        state <= S_IDLE;
                        cnt   <= 32'd0;
                        busy  <= 1'b0;
                    end else if (cnt_zero) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 32'd0;
                    led   <= 4'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CUE_PLAYER_TONE_EN
    logic [31:0] tcnt;
    logic [1:0]  tcolor;

    function automatic logic [31:0] half_ld(input logic [1:0] c);
        case (c)
            2'd0:    half_ld = TONE_HALF0 - 32'd1;
            2'd1:    half_ld = TONE_HALF1 - 32'd1;
            2'd2:    half_ld = TONE_HALF2 - 32'd1;
            default: half_ld = TONE_HALF3 - 32'd1;
        endcase
    endfunction

    // Runs only while ON continues into the next cycle; any exit
    // from ON (end of duration, stop) silences the buzzer.
    always_ff @(posedge clk) begin
        if (reset) begin
            tone   <= 1'b0;
            tcnt   <= 32'd0;
            tcolor <= 2'd0;
        end else if (accept) begin
            tone   <= 1'b0;
            tcnt   <= half_ld(req_color);
            tcolor <= req_color;
        end else if (state == S_ON && !stop && !cnt_zero) begin
            if (tcnt == 32'd0) begin
                tone <= ~tone;
                tcnt <= half_ld(tcolor);
            end else begin
                tcnt <= tcnt - 32'd1;
            end
        end else begin
            tone <= 1'b0;
            tcnt <= 32'd0;
        end
    end
`else
    assign tone = 1'b0;
`endif

endmodule
